// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_ctrl_pkg;

    localparam int WB_ADDR_W = 4;
    localparam int WB_DATA_W = 32;
    localparam logic [WB_ADDR_W-1:0] REG_PC = 4'd15;
    localparam int NUM_GPR = 15;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // R15 maps to no scoreboard bit, so it yields an all-zero mask.
    function automatic logic [NUM_GPR-1:0] gpr_onehot(input logic [WB_ADDR_W-1:0] a);
        logic [NUM_GPR-1:0] v;
        v = '0;
        if (a != REG_PC) begin
            v = {{(NUM_GPR-1){1'b0}}, 1'b1} << a;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; push is ignored when full, pop when empty.
module wb_fifo
    import regfile_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == DEPTH_CNT);
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_req;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU and load writebacks onto the regfile write port,
// with a scoreboard of registers that still have a write in flight.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic [14:0]       pending,
    output logic              drop_r15,
    output logic              idle
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_req_t            alu_req_s, mem_req_s, alu_head_s, mem_head_s, head_s;
    logic               alu_empty_s, alu_full_s, mem_empty_s, mem_full_s;
    logic [CNT_W-1:0]   alu_count_s, mem_count_s;
    grant_t             grant_s, last_grant_r;
    logic [NUM_GPR-1:0] pending_r, set_s, clr_s;

    assign alu_req_s = '{addr: alu_addr, data: alu_data};
    assign mem_req_s = '{addr: mem_addr, data: mem_data};
    // A full FIFO refuses input even when it is being popped this cycle.
    assign alu_ready = !alu_full_s;
    assign mem_ready = !mem_full_s;
    assign pending   = pending_r;
    assign idle      = (alu_count_s == CNT_W'(0)) && (mem_count_s == CNT_W'(0)) && !we3;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .reset(reset),
        .push(alu_valid && alu_ready), .push_req(alu_req_s),
        .pop(grant_s == GNT_ALU), .head(alu_head_s),
        .empty(alu_empty_s), .full(alu_full_s), .count(alu_count_s)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk(clk), .reset(reset),
        .push(mem_valid && mem_ready), .push_req(mem_req_s),
        .pop(grant_s == GNT_MEM), .head(mem_head_s),
        .empty(mem_empty_s), .full(mem_full_s), .count(mem_count_s)
    );

    // Round-robin grant over the two FIFO heads.
    always_comb begin
        grant_s = GNT_NONE;
        if (!alu_empty_s && !mem_empty_s) begin
            grant_s = (last_grant_r == GNT_MEM) ? GNT_ALU : GNT_MEM;
        end else if (!alu_empty_s) begin
            grant_s = GNT_ALU;
        end else if (!mem_empty_s) begin
            grant_s = GNT_MEM;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Head of the granted requester.
    always_comb begin
        head_s = alu_head_s;
        if (grant_s == GNT_MEM) begin
            head_s = mem_head_s;
        end else begin
            head_s = alu_head_s;
        end
    end

    // Registered write port; R15 entries are consumed without a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3          <= 1'b0;
            wa3          <= '0;
            wd3          <= '0;
            drop_r15     <= 1'b0;
            last_grant_r <= GNT_ALU;
        end else begin
            case (grant_s)
                GNT_ALU, GNT_MEM: begin
                    last_grant_r <= grant_s;
                    if (head_s.addr == REG_PC) begin
                        we3      <= 1'b0;
                        drop_r15 <= 1'b1;
                    end else begin
                        we3      <= 1'b1;
                        wa3      <= head_s.addr;
                        wd3      <= head_s.data;
                        drop_r15 <= 1'b0;
                    end
                end
                default: begin
                    we3      <= 1'b0;
                    drop_r15 <= 1'b0;
                end
            endcase
        end
    end

    assign clr_s = we3 ? gpr_onehot(wa3) : '0;
    assign set_s = mark_valid ? gpr_onehot(mark_addr) : '0;

    // Scoreboard: a new reservation outranks a same-edge commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | set_s;
        end
    end

endmodule
